// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO-side read port and downstream ready/valid stream for fifo_reader.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_valid;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  ready;
    modport master (
        output fifo_empty, fifo_data, fifo_valid, ready,
        input  fifo_rd, data_out, valid
    );
    modport slave (
        input  fifo_empty, fifo_data, fifo_valid, ready,
        output fifo_rd, data_out, valid
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains a FIFO through a skid buffer onto a ready/valid stream.
// Define FIFO_READER_ERR_EN to build the sticky protocol checker behind err_reader.
module fifo_reader #(
    parameter int DATA_WIDTH = 6,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 enable,
    fifo_reader_if.slave         bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 err_reader
);
    localparam int OW = $clog2(SKID_DEPTH + 1);
    localparam int PW = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;
    localparam logic [OW:0]   FULL = (OW + 1)'(SKID_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic                  inflight_q, inflight_d;
    logic                  post_rst_q, post_rst_d;
    logic                  err_q, err_d;
    logic                  vld, pop, rd, live, over, cap, busy_d;
    logic [OW:0]           fill;

    always_comb begin
        vld = occ_q != '0;
        pop = vld && bus.ready;
        // slots committed after this cycle's pop: decides whether another read fits
        fill = (OW + 1)'(occ_q) + (OW + 1)'(inflight_q) - (OW + 1)'(pop);
        rd = !RESET && enable && !bus.fifo_empty && fill < FULL;
        live = bus.fifo_valid && !post_rst_q;
        over = live && (OW + 1)'(occ_q) == FULL && !pop;
`ifdef FIFO_READER_ERR_EN
        cap = live && inflight_q && !over;
        err_d = err_q || (live && (!inflight_q || over));
`else
        cap = live && !over;
        err_d = 1'b0;
`endif
        mem_d = mem_q;
        if (cap) mem_d[tail_q] = bus.fifo_data;
        tail_d = cap ? (tail_q == LAST ? '0 : tail_q + 1'b1) : tail_q;
        head_d = pop ? (head_q == LAST ? '0 : head_q + 1'b1) : head_q;
        occ_d = occ_q + OW'(cap) - OW'(pop);
        inflight_d = rd;
        rd_count_d = rd_count_q + CNT_WIDTH'(pop);
        post_rst_d = 1'b0;
        busy_d = inflight_d || occ_d != '0;
        state_d = state_q == IDLE ? ((rd || busy_d) ? RUN : IDLE)
                : state_q == RUN  ? ((!pop && fill == FULL) ? HOLD : (busy_d ? RUN : IDLE))
                : (pop ? RUN : HOLD);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            post_rst_q <= 1'b1;
            err_q      <= 1'b0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            post_rst_q <= post_rst_d;
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign bus.fifo_rd  = rd;
    assign bus.valid    = vld;
    assign bus.data_out = vld ? mem_q[head_q] : '0;
    assign busy         = inflight_q || vld;
    assign rd_count     = rd_count_q;
    assign err_reader   = err_q;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized and directed checks of fifo_reader against a queue-based model.
module tb_fifo_reader;
`ifdef FIFO_READER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET;
    logic       enable;
    logic       busy;
    logic [7:0] rd_count;
    logic       err_reader;

    fifo_reader_if #(.DATA_WIDTH(6)) bus();

    fifo_reader dut (
        .clk(clk), .RESET(RESET), .enable(enable), .bus(bus),
        .busy(busy), .rd_count(rd_count), .err_reader(err_reader)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0;
    int cyc = 0, rd_pulses = 0, first_valid = -1, base = 0;
    logic [5:0] src[$], mq[$], got[$];
    bit m_inflight, m_ign, m_err, src_resp;
    int m_cnt;
    logic [5:0] resp_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // one clock: drive inputs, compare against the model at negedge, advance model and source FIFO
    task automatic cycle(input bit en, input bit rdy, input bit rst_in, input bit force_v);
        bit e_valid, e_pop, e_rd, live, over, cap;
        logic [5:0] e_data;
        enable = en;
        bus.ready = rdy;
        RESET = rst_in;
        bus.fifo_valid = src_resp || force_v;
        bus.fifo_data = src_resp ? resp_word : (force_v ? 6'h2a : 6'h00);
        bus.fifo_empty = src.size() == 0;
        @(negedge clk);
        e_valid = mq.size() != 0;
        e_data = e_valid ? mq[0] : 6'h00;
        e_pop = e_valid && rdy;
        e_rd = !rst_in && en && src.size() != 0 && (mq.size() + int'(m_inflight) - int'(e_pop)) < 2;
        check("valid", 32'(bus.valid), 32'(e_valid));
        check("data_out", 32'(bus.data_out), 32'(e_data));
        check("fifo_rd", 32'(bus.fifo_rd), 32'(e_rd));
        check("busy", 32'(busy), 32'(m_inflight || e_valid));
        check("rd_count", 32'(rd_count), 32'(m_cnt));
        check("err", 32'(err_reader), 32'(m_err));
        if (bus.fifo_rd) rd_pulses++;
        if (bus.valid && first_valid < 0) first_valid = cyc;
        if (bus.valid && rdy) got.push_back(bus.data_out);
        live = bus.fifo_valid && !m_ign;
        if (rst_in) begin
            mq.delete();
            m_inflight = 1'b0;
            m_cnt = 0;
            m_err = 1'b0;
            m_ign = 1'b1;
        end else begin
            over = live && mq.size() == 2 && !e_pop;
            cap = live && !over && (!ERR_EN || m_inflight);
            if (ERR_EN && live && (!m_inflight || over)) m_err = 1'b1;
            if (e_pop) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 256;
            end
            if (cap) mq.push_back(bus.fifo_data);
            m_inflight = e_rd;
            m_ign = 1'b0;
        end
        src_resp = bus.fifo_rd && src.size() != 0;
        if (src_resp) resp_word = src.pop_front();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [5:0] first);
        for (int i = 0; i < n; i++) src.push_back(first + 6'(i));
    endtask

    initial begin
        RESET = 1'b1;
        enable = 1'b0;
        bus.ready = 1'b0;
        bus.fifo_valid = 1'b0;
        bus.fifo_data = '0;
        bus.fifo_empty = 1'b1;
        src_resp = 1'b0;
        m_inflight = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
        m_ign = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_rd", 32'(bus.fifo_rd), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(rd_count), 0);
        check("rst_err", 32'(err_reader), 0);

        // streaming with ready high
        load(5, 6'h01);
        got.delete();
        base = cyc;
        first_valid = -1;
        repeat (10) cycle(1, 1, 0, 0);
        check("t1_latency", 32'(first_valid - base), 2);
        check("t1_n", 32'(got.size()), 5);
        foreach (got[i]) check("t1_word", 32'(got[i]), 32'(i + 1));
        check("t1_cnt", 32'(rd_count), 5);
        check("t1_busy", 32'(busy), 0);

        // downstream stall
        cycle(0, 0, 1, 0);
        load(5, 6'h01);
        got.delete();
        rd_pulses = 0;
        repeat (6) cycle(1, 0, 0, 0);
        check("t2_rd_pulses", 32'(rd_pulses), 2);
        check("t2_hold_data", 32'(bus.data_out), 1);
        check("t2_hold_valid", 32'(bus.valid), 1);
        repeat (10) cycle(1, 1, 0, 0);
        check("t2_n", 32'(got.size()), 5);
        foreach (got[i]) check("t2_word", 32'(got[i]), 32'(i + 1));
        check("t2_cnt", 32'(rd_count), 5);

        // enable dropped right after a read
        cycle(0, 0, 1, 0);
        src.delete();
        load(3, 6'h11);
        got.delete();
        rd_pulses = 0;
        cycle(1, 1, 0, 0);
        repeat (4) cycle(0, 1, 0, 0);
        check("t3_rd_pulses", 32'(rd_pulses), 1);
        check("t3_n", 32'(got.size()), 1);
        if (got.size() > 0) check("t3_word", 32'(got[0]), 32'h11);
        check("t3_busy", 32'(busy), 0);

        // reset with a word buffered and one in flight
        cycle(0, 0, 1, 0);
        src.delete();
        load(3, 6'h21);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("t4_busy_pre", 32'(busy), 1);
        check("t4_valid_pre", 32'(bus.valid), 1);
        cycle(1, 0, 1, 0);
        check("t4_valid", 32'(bus.valid), 0);
        check("t4_data", 32'(bus.data_out), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_cnt", 32'(rd_count), 0);
        cycle(0, 0, 0, 1);
        check("t4_stray_valid", 32'(bus.valid), 0);
        check("t4_stray_err", 32'(err_reader), 0);

        // delivered-word counter wrap
        cycle(0, 0, 1, 0);
        src.delete();
        for (int i = 0; i < 300; i++) src.push_back(6'(i));
        for (int k = 0; k < 400 && m_cnt != 255; k++) cycle(1, 1, 0, 0);
        check("t5_cnt255", 32'(rd_count), 255);
        for (int k = 0; k < 5 && m_cnt != 0; k++) cycle(1, 1, 0, 0);
        check("t5_wrap", 32'(rd_count), 0);

        // random traffic
        cycle(0, 0, 1, 0);
        src.delete();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0 && src.size() < 6) src.push_back(6'($urandom));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 199) == 0, 1'b0);
        end

        // stray fifo_valid with nothing in flight
        cycle(0, 0, 1, 0);
        src.delete();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("t7_err", 32'(err_reader), 32'(ERR_EN));
        repeat (3) cycle(0, 1, 0, 0);
        check("t7_sticky", 32'(err_reader), 32'(ERR_EN));
        cycle(0, 0, 1, 0);
        check("t7_clear", 32'(err_reader), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
